// File: rtl/microwave_controller.sv
// rtl/microwave_controller.sv - microwave cook-cycle sequencer: tick prescaler, BCD mm:ss timer, FSM, interlock
// Optional MW_QUICK_START_EN: btn_start in IDLE loads 00:30 and cooks immediately.
module microwave_controller #(
  parameter int TICKS_PER_SEC = 500,
  parameter int BEEP_SECS     = 3
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       door_open,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_min,
  input  logic       btn_sec,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       magnetron,
  output logic       lamp,
  output logic       beep,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int BW = (BEEP_SECS > 1) ? $clog2(BEEP_SECS + 1) : 1;

  state_t        state_q, state_d;
  logic [15:0]   tmr_q, tmr_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
  logic          tick_prev_q;
  logic          sec_pulse_q, sec_pulse_d;
  logic          magnetron_q, lamp_q, beep_q;

  logic          tick_edge;
  logic          any_add;
  logic          counting;
  logic          entry;
  logic [15:0]   added;
  logic [15:0]   decd;

  // Time is {min_tens, min_ones, sec_tens, sec_ones}; tens-of-seconds overflow carries into minutes.
  function automatic logic [15:0] bcd_add(input logic [15:0] t, input logic add_m, input logic add_s);
    logic [3:0]  st, mo, mt;
    logic [1:0]  inc;
    logic [15:0] res;
    st  = t[7:4];
    inc = {1'b0, add_m};
    if (add_s) begin
      if (st >= 4'd5) begin
        st  = st - 4'd5;
        inc = inc + 2'd1;
      end else begin
        st = st + 4'd1;
      end
    end
    mo = t[11:8] + {2'b00, inc};
    mt = t[15:12];
    if (mo >= 4'd10) begin
      mo = mo - 4'd10;
      mt = mt + 4'd1;
    end
    if (mt >= 4'd10) res = 16'h9959;
    else             res = {mt, mo, st, t[3:0]};
    return res;
  endfunction

  function automatic logic [7:0] bcd_dec8(input logic [7:0] v);
    logic [7:0] res;
    if (v[3:0] != 4'd0) res = {v[7:4], v[3:0] - 4'd1};
    else                res = {v[7:4] - 4'd1, 4'd9};
    return res;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [15:0] res;
    if (t[7:0] != 8'h00) res = {t[15:8], bcd_dec8(t[7:0])};
    else                 res = {bcd_dec8(t[15:8]), 8'h59};
    return res;
  endfunction

  assign tick_edge = tick_in & ~tick_prev_q;
  assign any_add   = btn_min | btn_sec;
  assign added     = bcd_add(tmr_q, btn_min, btn_sec);
  assign decd      = bcd_dec(tmr_q);

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    beep_cnt_d = (state_q == S_DONE) ? beep_cnt_q : '0;
    case (state_q)
      S_IDLE: begin
        if (!btn_stop) begin
          if (any_add) begin
            tmr_d   = added;
            state_d = S_SET;
          end
`ifdef MW_QUICK_START_EN
          if (btn_start && !door_open) begin
            tmr_d   = 16'h0030;
            state_d = S_COOK;
          end
`endif
        end
      end
      S_SET: begin
        if (btn_stop) begin
          tmr_d   = 16'h0000;
          state_d = S_IDLE;
        end else begin
          if (any_add) tmr_d = added;
          if (btn_start && !door_open) state_d = S_COOK;
        end
      end
      S_COOK: begin
        // An add in the same cycle as sec_pulse swallows that second's decrement.
        if (any_add) begin
          tmr_d = added;
        end else if (sec_pulse_q && tmr_q != 16'h0000) begin
          tmr_d = decd;
          if (decd == 16'h0000) state_d = S_DONE;
        end
        if (state_d != S_DONE && (door_open || btn_stop)) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (btn_stop) begin
          tmr_d   = 16'h0000;
          state_d = S_IDLE;
        end else begin
          if (any_add) tmr_d = added;
          if (btn_start && !door_open) state_d = S_COOK;
        end
      end
      S_DONE: begin
        if (btn_stop) begin
          state_d = S_IDLE;
        end else if (sec_pulse_q) begin
          if (beep_cnt_q == BW'(BEEP_SECS - 1)) state_d = S_IDLE;
          else                                  beep_cnt_d = beep_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tmr_d   = 16'h0000;
      end
    endcase
  end

  // Prescaler restarts on every entry into COOK or DONE, dropping any partial second.
  assign counting = (state_q == S_COOK) || (state_q == S_DONE);
  assign entry    = ((state_d == S_COOK) || (state_d == S_DONE)) && (state_d != state_q);

  always_comb begin
    presc_d     = presc_q;
    sec_pulse_d = 1'b0;
    if (entry) begin
      presc_d = '0;
    end else if (counting && tick_edge) begin
      if (presc_q == PW'(TICKS_PER_SEC - 1)) begin
        presc_d     = '0;
        sec_pulse_d = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tmr_q       <= 16'h0000;
      presc_q     <= '0;
      beep_cnt_q  <= '0;
      tick_prev_q <= 1'b0;
      sec_pulse_q <= 1'b0;
      magnetron_q <= 1'b0;
      lamp_q      <= 1'b0;
      beep_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      presc_q     <= presc_d;
      beep_cnt_q  <= beep_cnt_d;
      tick_prev_q <= tick_in;
      sec_pulse_q <= sec_pulse_d;
      magnetron_q <= (state_d == S_COOK);
      lamp_q      <= door_open | (state_d == S_COOK);
      beep_q      <= (state_d == S_DONE);
    end
  end

  assign min_bcd   = tmr_q[15:8];
  assign sec_bcd   = tmr_q[7:0];
  assign magnetron = magnetron_q;
  assign lamp      = lamp_q;
  assign beep      = beep_q;
  assign state     = state_q;

endmodule

// File: tb/tb_microwave_controller.sv
// tb/tb_microwave_controller.sv - directed self-checking bench for microwave_controller
module tb_microwave_controller;

  logic       clock_in = 1'b0;
  logic       reset = 1'b1;
  logic       tick_in = 1'b0;
  logic       door_open = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_stop = 1'b0;
  logic       btn_min = 1'b0;
  logic       btn_sec = 1'b0;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       magnetron;
  logic       lamp;
  logic       beep;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;

  microwave_controller #(.TICKS_PER_SEC(4), .BEEP_SECS(2)) dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .tick_in   (tick_in),
    .door_open (door_open),
    .btn_start (btn_start),
    .btn_stop  (btn_stop),
    .btn_min   (btn_min),
    .btn_sec   (btn_sec),
    .min_bcd   (min_bcd),
    .sec_bcd   (sec_bcd),
    .magnetron (magnetron),
    .lamp      (lamp),
    .beep      (beep),
    .state     (state)
  );

  always #5 clock_in = ~clock_in;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_in = 1'b1;
      step();
      tick_in = 1'b0;
      step();
    end
  endtask

  task automatic press_sec();
    btn_sec = 1'b1; step(); btn_sec = 1'b0;
  endtask

  task automatic press_min();
    btn_min = 1'b1; step(); btn_min = 1'b0;
  endtask

  task automatic press_start();
    btn_start = 1'b1; step(); btn_start = 1'b0;
  endtask

  task automatic press_stop();
    btn_stop = 1'b1; step(); btn_stop = 1'b0;
  endtask

  initial begin
    step();
    step();
    chk("rst_state", {13'd0, state}, 16'd0);
    chk("rst_time", {min_bcd, sec_bcd}, 16'h0000);
    chk("rst_outs", {13'd0, magnetron, lamp, beep}, 16'd0);
    reset = 1'b0;
    step();

    press_start();
`ifdef MW_QUICK_START_EN
    chk("qs_state", {13'd0, state}, 16'd2);
    chk("qs_time", {min_bcd, sec_bcd}, 16'h0030);
    press_stop();
    press_stop();
    chk("qs_back_idle", {13'd0, state}, 16'd0);
`else
    chk("qs_off_state", {13'd0, state}, 16'd0);
    chk("qs_off_time", {min_bcd, sec_bcd}, 16'h0000);
`endif

    // basic cook from 00:10
    press_sec();
    chk("set_state", {13'd0, state}, 16'd1);
    chk("set_time", {min_bcd, sec_bcd}, 16'h0010);
    press_start();
    chk("cook_state", {13'd0, state}, 16'd2);
    chk("cook_mag_lamp", {14'd0, magnetron, lamp}, 16'b11);
    ticks(3);
    chk("cook_3edges", {min_bcd, sec_bcd}, 16'h0010);
    ticks(1);
    chk("cook_1s", {min_bcd, sec_bcd}, 16'h0009);
    ticks(8);
    chk("cook_3s", {min_bcd, sec_bcd}, 16'h0007);

    // door interlock
    door_open = 1'b1;
    step();
    chk("door_state", {13'd0, state}, 16'd3);
    chk("door_mag_lamp", {14'd0, magnetron, lamp}, 16'b01);
    ticks(4);
    chk("door_frozen", {min_bcd, sec_bcd}, 16'h0007);
    press_start();
    chk("door_start_blocked", {13'd0, state}, 16'd3);
    door_open = 1'b0;
    step();
    chk("door_closed_lamp", {15'd0, lamp}, 16'd0);
    press_start();
    chk("resume_state", {13'd0, state}, 16'd2);
    chk("resume_mag", {15'd0, magnetron}, 16'd1);
    ticks(8);
    chk("resume_time", {min_bcd, sec_bcd}, 16'h0005);

    // add coinciding with sec_pulse at 00:05
    ticks(3);
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    btn_sec = 1'b1;
    step();
    btn_sec = 1'b0;
    chk("add_on_pulse", {min_bcd, sec_bcd}, 16'h0015);
    ticks(56);
    chk("cook_to_01", {min_bcd, sec_bcd}, 16'h0001);
    ticks(3);
    chk("not_done_yet", {13'd0, state}, 16'd2);
    ticks(1);
    chk("done_time", {min_bcd, sec_bcd}, 16'h0000);
    chk("done_state", {13'd0, state}, 16'd4);
    chk("done_outs", {13'd0, magnetron, lamp, beep}, 16'b001);
    ticks(7);
    chk("beeping", {12'd0, beep, state}, 16'b1100);
    ticks(1);
    chk("beep_end", {12'd0, beep, state}, 16'b0000);

    // borrow and carry
    press_min();
    chk("min_set", {min_bcd, sec_bcd}, 16'h0100);
    press_start();
    ticks(4);
    chk("borrow", {min_bcd, sec_bcd}, 16'h0059);
    ticks(16);
    chk("at_0055", {min_bcd, sec_bcd}, 16'h0055);
    press_sec();
    chk("carry", {min_bcd, sec_bcd}, 16'h0105);
    press_stop();
    chk("stop_pause", {13'd0, state}, 16'd3);
    chk("stop_pause_time", {min_bcd, sec_bcd}, 16'h0105);
    press_stop();
    chk("stop_idle", {13'd0, state}, 16'd0);
    chk("stop_clear", {min_bcd, sec_bcd}, 16'h0000);

    // saturation
    for (int i = 0; i < 99; i++) press_min();
    chk("min_99", {min_bcd, sec_bcd}, 16'h9900);
    for (int i = 0; i < 5; i++) press_sec();
    chk("at_9950", {min_bcd, sec_bcd}, 16'h9950);
    press_sec();
    chk("sat_sec", {min_bcd, sec_bcd}, 16'h9959);
    press_min();
    chk("sat_min", {min_bcd, sec_bcd}, 16'h9959);
    btn_start = 1'b1;
    btn_stop = 1'b1;
    step();
    btn_start = 1'b0;
    btn_stop = 1'b0;
    chk("start_stop_state", {13'd0, state}, 16'd0);
    chk("start_stop_time", {min_bcd, sec_bcd}, 16'h0000);

    // door beats start in SET
    press_sec();
    door_open = 1'b1;
    press_start();
    chk("door_blocks_set", {13'd0, state}, 16'd1);
    door_open = 1'b0;
    press_stop();

    // async reset mid-cook
    press_sec();
    press_start();
    chk("pre_reset_mag", {15'd0, magnetron}, 16'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_outs", {13'd0, magnetron, lamp, beep}, 16'd0);
    chk("async_state", {13'd0, state}, 16'd0);
    chk("async_time", {min_bcd, sec_bcd}, 16'h0000);
    step();
    reset = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/microwave_controller.md
# microwave_controller

Cook-cycle sequencer for the microwave oven design. Consumes the square-wave tick from the 500 Hz clock divider and counts it down into seconds. Runs the mm:ss BCD cook timer from the front-panel pulses. Drives the magnetron enable, cavity lamp and end-of-cycle beeper, and enforces the door interlock.

## Interface
- `TICKS_PER_SEC`, default 500: tick rising edges per second (the divider output frequency).
- `BEEP_SECS`, default 3: seconds the beeper sounds in DONE.
- `clock_in`: input, 1 bit, system clock; all logic is on its rising edge.
- `reset`: input, 1 bit, asynchronous, active-high; clears all state.
- `tick_in`: input, 1 bit, divider output; a level signal synchronous to `clock_in`.
- `door_open`: input, 1 bit, door switch level; 1 means open.
- `btn_start`: input, 1 bit, start pulse, one `clock_in` cycle wide, already debounced.
- `btn_stop`: input, 1 bit, stop/clear pulse, one cycle wide.
- `btn_min`: input, 1 bit, add 1 minute, one-cycle pulse.
- `btn_sec`: input, 1 bit, add 10 seconds, one-cycle pulse.
- `min_bcd`: output, 8 bits, minutes as two BCD digits (00–99).
- `sec_bcd`: output, 8 bits, seconds as two BCD digits (00–59).
- `magnetron`: output, 1 bit, power enable; 1 only in COOK.
- `lamp`: output, 1 bit, cavity lamp.
- `beep`: output, 1 bit, buzzer enable.
- `state`: output, 3 bits, encoding IDLE=0, SET=1, COOK=2, PAUSE=3, DONE=4.

## Operation
- Tick edge detection:
  - `tick_prev` register, reset 0.
  - `tick_edge = tick_in & ~tick_prev`.
- Prescaler:
  - Counts `tick_edge` only in COOK and DONE.
  - When an edge arrives with the count at `TICKS_PER_SEC-1`, it emits a one-cycle `sec_pulse` and returns to 0.
  - It is cleared to 0 on every entry into COOK or DONE.
- Time adds:
  - `btn_min`: mm+1.
  - `btn_sec`: ss+10; if ss ≥ 60, subtract 60 and carry 1 into mm.
  - Any result above 99:59 saturates to 99:59.
  - Adds are accepted in IDLE, SET, COOK and PAUSE, and ignored in DONE.
  - If both buttons pulse together, both adds apply, then saturation.
- Decrement on `sec_pulse` in COOK:
  - If ss > 0: ss−1.
  - Otherwise: ss=59, mm−1.
  - All arithmetic is BCD; every digit stays in 0–9 at all times.
- FSM transitions:
  - IDLE (time 00:00): an add → SET. `btn_start` is handled as described under Configuration.
  - SET:
    - `btn_start` with the door closed → COOK.
    - `btn_stop` → time 00:00, IDLE.
  - COOK:
    - A decrement that reaches 00:00 → DONE.
    - `door_open` = 1 → PAUSE.
    - `btn_stop` → PAUSE.
  - PAUSE:
    - `btn_start` with the door closed → COOK. The prescaler restarts, so the partial second is lost.
    - `btn_stop` → 00:00, IDLE.
  - DONE:
    - After `BEEP_SECS` `sec_pulse`s → IDLE.
    - `btn_stop` → IDLE immediately.
    - `btn_start` is ignored.
- Priorities in a single cycle:
  - `reset` overrides everything.
  - `btn_stop` beats `btn_start`.
  - `door_open` beats `btn_start`, so the FSM stays in SET or PAUSE.
  - An add coinciding with `sec_pulse` in COOK is applied and that second's decrement is skipped.
  - `door_open` coinciding with the `sec_pulse` that reaches 00:00 → DONE. Completion wins.
- Outputs:
  - `magnetron` = (state == COOK).
  - `lamp` = `door_open` | (state == COOK), registered.
  - `beep` = (state == DONE).

## Timing
- Reset values:
  - `state` = IDLE.
  - `min_bcd` = `sec_bcd` = 8'h00.
  - `magnetron` = 0, `lamp` = 0, `beep` = 0.
  - Prescaler = 0, `tick_prev` = 0.
- Every output is registered. A button pulse in cycle N is visible in `state`, the time digits and the outputs at cycle N+1.
- `sec_pulse` is registered; time changes one cycle after the completing `tick_edge` is detected. Worst-case decrement latency is 2 cycles after `tick_in` rises.
- Door interlock: `magnetron` falls within 1 cycle of `door_open` rising.
- The transition to DONE and `beep` = 1 occur on the same edge that the time reaches 00:00.
- `reset` asserted mid-cook drops `magnetron` asynchronously and clears the time.

## Configuration
- The feature is selected by the macro `MW_QUICK_START_EN`.
- Defined: `btn_start` in IDLE with the door closed loads 00:30 and enters COOK directly, at the same N+1 timing.
- Undefined: `btn_start` in IDLE is ignored; time stays 00:00 and the state stays IDLE.

## Test plan
Simulation uses `TICKS_PER_SEC`=4 and `BEEP_SECS`=2.
- **Basic cook:** `btn_sec`×1, then `btn_start` → the timer shows 00:10, then decrements 1 per 4 tick edges. At 00:00, `state` = 4 and `beep` = 1 for 8 tick edges, then `state` = 0 and `beep` = 0.
- **Door interlock:** raise `door_open` at 00:07 → next cycle `magnetron` = 0, `state` = 3, time frozen at 00:07, `lamp` = 1. `btn_start` with the door open → still 3. Close the door, then `btn_start` → 2.
- **Carry and saturation:** from 00:55, `btn_sec` → 01:05. From 99:50, `btn_sec` then `btn_min` → 99:59.
- **Borrow:** cook from 01:00 → the next second shows 00:59, with valid BCD on every digit.
- **Simultaneous events:**
  - `btn_start` and `btn_stop` together in SET → IDLE, 00:00.
  - `btn_sec` coinciding with `sec_pulse` at 00:05 → 00:15.
- **Reset and macro:**
  - Async `reset` mid-COOK → all outputs 0 without waiting for a clock edge.
  - IDLE `btn_start` → COOK at 00:30 with `MW_QUICK_START_EN` defined; stays IDLE at 00:00 without it.
